quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_pkg.sv | 42 ++++
 rtl/quad_decoder_debounce.sv | 58 +++++
 rtl/quad_decoder.sv | 95 +++++++++
 tb/tb_quad_decoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: the {A,B} phase, step classification
// and the forward-successor relation 00->01->11->10->00.
package quad_pkg;

  typedef logic [1:0] quad_state_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } quad_step_t;

  localparam quad_state_t FWD_NEXT_00 = 2'b01;
  localparam quad_state_t FWD_NEXT_01 = 2'b11;
  localparam quad_state_t FWD_NEXT_11 = 2'b10;
  localparam quad_state_t FWD_NEXT_10 = 2'b00;

  // Edges after reset release during which the filters simply track the synchronizers.
  localparam logic [1:0] WARM_EDGES = 2'd3;

  function automatic quad_state_t quad_fwd_next(input quad_state_t s);
    quad_state_t n;
    case (s)
      2'b00:   n = FWD_NEXT_00;
      2'b01:   n = FWD_NEXT_01;
      2'b11:   n = FWD_NEXT_11;
      default: n = FWD_NEXT_10;
    endcase
    return n;
  endfunction

  function automatic quad_step_t quad_classify(input quad_state_t prev, input quad_state_t curr);
    quad_step_t st;
    if (curr == prev)                     st = STEP_NONE;
    else if (curr == quad_fwd_next(prev)) st = STEP_FWD;
    else if (prev == quad_fwd_next(curr)) st = STEP_REV;
    else                                  st = STEP_ERR;
    return st;
  endfunction

endpackage

// File: rtl/quad_decoder_debounce.sv
// One encoder channel: 2-flop synchronizer, then a level is accepted only after it
// has been held filter_cycles_p edges at the synchronizer output.
module debounce #(
  parameter int filter_cycles_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic din_i,
  input  logic load_i,
  output logic sync_o,
  output logic filt_o
);

  localparam int CNT_W = $clog2(filter_cycles_p + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(filter_cycles_p - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q,  filt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = din_i;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else if (sync2_q == filt_q) begin
      // Also covers a level that toggles back before acceptance.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o = sync2_q;
  assign filt_o = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: debounced A/B phases -> registered up/down/err step pulses.
// Pulse is high in the cycle after edge filter_cycles_p+3 counted from the input change.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int filter_cycles_p = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       up_o,
  output logic       down_o,
  output logic       err_o,
  output logic [1:0] state_o
);

  logic        a_sync, b_sync;
  logic        a_filt, b_filt;
  logic        warm;
  quad_state_t sync_pair, filt_pair;
  quad_step_t  step;

  logic [1:0]  warm_cnt_q, warm_cnt_d;
  quad_state_t prev_q,     prev_d;
  logic        up_q,       up_d;
  logic        down_q,     down_d;
  logic        err_q,      err_d;

  assign warm = (warm_cnt_q != WARM_EDGES);

  debounce #(.filter_cycles_p(filter_cycles_p)) u_deb_a (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .din_i   (a_i),
    .load_i  (warm),
    .sync_o  (a_sync),
    .filt_o  (a_filt)
  );

  debounce #(.filter_cycles_p(filter_cycles_p)) u_deb_b (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .din_i   (b_i),
    .load_i  (warm),
    .sync_o  (b_sync),
    .filt_o  (b_filt)
  );

  assign sync_pair = {a_sync, b_sync};
  assign filt_pair = {a_filt, b_filt};
  assign step      = quad_classify(prev_q, filt_pair);

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    prev_d     = filt_pair;
    up_d       = 1'b0;
    down_d     = 1'b0;
    err_d      = 1'b0;
    if (warm) begin
      // Previous pair follows the value the filters load, so edge 4 sees no change.
      warm_cnt_d = warm_cnt_q + 2'd1;
      prev_d     = sync_pair;
    end else begin
      case (step)
        STEP_FWD: up_d   = 1'b1;
        STEP_REV: down_d = 1'b1;
        STEP_ERR: err_d  = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      warm_cnt_q <= 2'd0;
      prev_q     <= 2'b00;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      prev_q     <= prev_d;
      up_q       <= up_d;
      down_q     <= down_d;
      err_q      <= err_d;
    end
  end

  assign up_o    = up_q;
  assign down_o  = down_q;
  assign err_o   = err_q;
  assign state_o = filt_pair;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with filter_cycles_p = 4.
module tb_quad_decoder;

  logic       clk_i;
  logic       reset_i;
  logic       a_i;
  logic       b_i;
  logic       up_o;
  logic       down_o;
  logic       err_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;
  int up_cnt   = 0;
  int down_cnt = 0;
  int err_cnt  = 0;

  quad_decoder #(.filter_cycles_p(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .up_o    (up_o),
    .down_o  (down_o),
    .err_o   (err_o),
    .state_o (state_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic clear_counts();
    up_cnt   = 0;
    down_cnt = 0;
    err_cnt  = 0;
  endtask

  always @(negedge clk_i) begin
    if (up_o)   up_cnt++;
    if (down_o) down_cnt++;
    if (err_o)  err_cnt++;
    if (up_o || down_o || err_o)
      check("onehot", int'(up_o) + int'(down_o) + int'(err_o), 1);
  end

  initial begin
    logic [1:0] rev_seq [4];
    rev_seq[0] = 2'b10;
    rev_seq[1] = 2'b11;
    rev_seq[2] = 2'b01;
    rev_seq[3] = 2'b00;

    // Reset held with encoder resting at 11.
    reset_i = 1'b0;
    a_i     = 1'b1;
    b_i     = 1'b1;
    tick(3);
    check("rst_up",    int'(up_o),    0);
    check("rst_down",  int'(down_o),  0);
    check("rst_err",   int'(err_o),   0);
    check("rst_state", int'(state_o), 0);
    clear_counts();
    reset_i = 1'b1;
    tick(10);
    check("warm_state", int'(state_o), 3);
    check("warm_pulses", up_cnt + down_cnt + err_cnt, 0);

    // Single forward step 00 -> 01, exact latency.
    reset_i = 1'b0;
    a_i     = 1'b0;
    b_i     = 1'b0;
    tick(2);
    reset_i = 1'b1;
    tick(10);
    check("idle_state", int'(state_o), 0);
    clear_counts();
    b_i = 1'b1;
    tick(6);
    check("fwd_e6_up", int'(up_o), 0);
    check("fwd_e6_state", int'(state_o), 1);
    tick(1);
    check("fwd_e7_up",   int'(up_o),   1);
    check("fwd_e7_down", int'(down_o), 0);
    check("fwd_e7_err",  int'(err_o),  0);
    tick(1);
    check("fwd_e8_up", int'(up_o), 0);
    tick(4);
    check("fwd_up_cnt", up_cnt, 1);

    // Return to 00 (one reverse step), then a full reverse cycle.
    b_i = 1'b0;
    tick(10);
    check("back_down_cnt", down_cnt, 1);
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      {a_i, b_i} = rev_seq[i];
      tick(10);
    end
    check("rev_down_cnt", down_cnt, 4);
    check("rev_up_cnt",   up_cnt,   0);
    check("rev_err_cnt",  err_cnt,  0);
    check("rev_state",    int'(state_o), 0);

    // Three-cycle glitch on A is rejected.
    clear_counts();
    a_i = 1'b1;
    tick(3);
    a_i = 1'b0;
    tick(15);
    check("glitch_pulses", up_cnt + down_cnt + err_cnt, 0);
    check("glitch_state",  int'(state_o), 0);

    // Both channels rise together: illegal transition.
    clear_counts();
    a_i = 1'b1;
    b_i = 1'b1;
    tick(12);
    check("both_err_cnt", err_cnt, 1);
    check("both_updown",  up_cnt + down_cnt, 0);
    check("both_state",   int'(state_o), 3);

    // Forward step 11 -> 10, then reset asserted while the pulse is high.
    b_i = 1'b0;
    tick(7);
    check("pre_rst_up",    int'(up_o),    1);
    check("pre_rst_state", int'(state_o), 2);
    #1;
    reset_i = 1'b0;
    #1;
    check("async_rst_up",    int'(up_o),    0);
    check("async_rst_state", int'(state_o), 0);
    tick(2);
    check("held_rst_up", int'(up_o), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
